aes_key_schedule: RTL and testbench
===================================

// Module: aes_key_schedule
// PURPOSE
//  Parametrised AES key expander: runtime-selected AES-128/192/256, one 32-bit schedule word per cycle.
//  Round keys are held in an internal flop word file and served on a read port.
//  The read port reports per-round validity, so the cipher core can start on early rounds mid-expansion.
//  Sits between the key-load CSR path and the aes cipher round datapath.
// PARAMETERS
//  MAX_KEY_BITS  256  largest supported key (128|192|256); word file depth = 4*(MAX_NR+1) words.
//  RD_LATENCY    1    read latency in cycles (0 = combinational key_out, 1 = registered key_out).
// PORTS
//  clk_in            in   1    clock; all logic on posedge
//  rst_n_in          in   1    reset, asynchronous, active-low
//  init_in           in   1    start expansion; sampled every cycle
//  key_len_in        in   2    0=AES-128, 1=AES-192, 2=AES-256, 3=illegal; sampled with init_in
//  key_in            in   256  cipher key, FIPS-197 byte order, MSB-aligned (w0 = [255:224]); unused LSBs ignored
//  round_rd_in       in   4    round-key index to read, 0..Nr
//  key_out           out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96]
//  rd_valid_out      out  1    requested round fully generated for the current key
//  busy_out          out  1    expansion in progress
//  key_expanded_out  out  1    all Nr+1 round keys valid for the current key
//  nr_out            out  4    Nr of the current key (10/12/14); 0 after reset
//  err_out           out  1    last init was rejected (illegal/unsupported key_len_in); sticky
// BEHAVIOUR
//  Reset (rst_n_in low, async): FSM=IDLE, word count=0, all outputs 0; word file is NOT cleared.
//  Nk=4/6/8, Nr=10/12/14, total words T=4*(Nr+1)=44/52/60.
//  FSM IDLE/DONE --init_in--> EXPAND. On the init edge:
//   - w[0..Nk-1] are loaded from key_in; count=Nk.
//   - key_expanded_out clears; busy_out sets; err_out clears.
//  EXPAND, each edge: write w[i]; i=count, then count++.
//   - i%Nk==0: w[i]=w[i-Nk]^SubWord(RotWord(w[i-1]))^Rcon[i/Nk]
//   - Nk==8 && i%8==4: w[i]=w[i-8]^SubWord(w[i-1])
//   - otherwise: w[i]=w[i-Nk]^w[i-1]
//   - Rcon is generated by a GF(2^8) xtime register (01,02,..,1b,36); it advances on each i%Nk==0 write.
//  Word i (i>=Nk) is written on edge init+(i-Nk+1).
//  The last word is written at init+40/46/52; on that same edge busy_out->0, key_expanded_out->1, FSM=DONE.
//  init_in while EXPAND aborts the current expansion and restarts with the new key (same as from IDLE).
//  Illegal init (key_len_in==3, or key size > MAX_KEY_BITS):
//   - no state change, except err_out->1 on the next edge;
//   - prior keys and flags are retained.
//  rd_valid_out = (4*round_rd_in+3 < count) && (round_rd_in <= Nr); it follows RD_LATENCY alignment with key_out.
//  key_out is read from the word file; its value when rd_valid_out=0 is don't-care.
//  RD_LATENCY=1: key_out/rd_valid_out reflect round_rd_in from the previous edge; reset to 0.
//  Reading a round that is written on the same edge returns the new word (write-first bypass).
// TESTING
//  1 FIPS-197 A.1, AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
//    key_expanded_out high 40 edges after init;
//    round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 0 = key.
//  2 FIPS-197 A.2, AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//    done after 46 edges; round 12 = e98ba06f448c773c8ecc720401002202.
//  3 FIPS-197 A.3, AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//    done after 52 edges; round 14 = fe4890d1e6188d0b046df344706c631e.
//  4 Early read, AES-128: hold round_rd_in=2.
//    rd_valid_out must rise exactly when w[11] is written (edge init+8, +RD_LATENCY), never earlier.
//  5 Abort/illegal init:
//    init AES-256 key, re-init AES-128 at edge +20 -> round 10 matches test 1;
//    then init key_len_in=3 -> err_out=1 and rounds still read test 1 values.
//  6 Reset: drop rst_n_in mid-EXPAND (async, between edges).
//    All outputs 0 immediately; round_rd_in sweep 0..15 gives rd_valid_out=0; re-init then completes normally.

Source files
------------

// File: rtl/aes_key_schedule_if.sv
// Key-load control and round-key read bundle between the cipher side and the AES key expander.
interface aes_key_schedule_if;
    logic         init_in;
    logic [1:0]   key_len_in;
    logic [255:0] key_in;
    logic [3:0]   round_rd_in;
    logic [127:0] key_out;
    logic         rd_valid_out;
    logic         busy_out;
    logic         key_expanded_out;
    logic [3:0]   nr_out;
    logic         err_out;

    modport master (
        output init_in, key_len_in, key_in, round_rd_in,
        input  key_out, rd_valid_out, busy_out, key_expanded_out, nr_out, err_out
    );
    modport slave (
        input  init_in, key_len_in, key_in, round_rd_in,
        output key_out, rd_valid_out, busy_out, key_expanded_out, nr_out, err_out
    );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expander: one schedule word per cycle into a flop word file,
// with a round-key read port that flags rounds already generated for the current key.
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RD_LATENCY   = 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    aes_key_schedule_if.slave ks
);
    localparam int MAX_NR = (MAX_KEY_BITS >= 256) ? 14 : ((MAX_KEY_BITS >= 192) ? 12 : 10);
    localparam int DEPTH  = 4 * (MAX_NR + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

    state_t       state_r;
    logic [5:0]   count_r, total_r;
    logic [3:0]   nk_r, nr_r, kmod_r;
    logic [7:0]   rcon_r;
    logic         busy_r, expanded_r, err_r;
    logic [31:0]  words_r [DEPTH];

    logic         legal_s, start_s, wr_en_s, last_s, rd_valid_s;
    logic [3:0]   nk_s, nr_s;
    logic [31:0]  prev_s, back_s, sub_src_s, sub_s, new_word_s;
    logic [127:0] rd_key_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            acc = acc ^ (b[k] ? x : 8'h00);
            x   = xtime(x);
        end
        return acc;
    endfunction

    // S-box as inverse (a^254, which also maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Key length decode; sizes above MAX_KEY_BITS are rejected like code 3
    always_comb begin
        legal_s = 1'b1;
        nk_s    = 4'd4;
        nr_s    = 4'd10;
        case (ks.key_len_in)
            2'd0: begin
                nk_s = 4'd4;
                nr_s = 4'd10;
            end
            2'd1: begin
                nk_s    = 4'd6;
                nr_s    = 4'd12;
                legal_s = (MAX_KEY_BITS >= 192);
            end
            2'd2: begin
                nk_s    = 4'd8;
                nr_s    = 4'd14;
                legal_s = (MAX_KEY_BITS >= 256);
            end
            default: legal_s = 1'b0;
        endcase
    end

    assign start_s = ks.init_in & legal_s;
    assign wr_en_s = (state_r == EXPAND) & ~start_s;
    assign last_s  = (count_r == (total_r - 6'd1));

    // Next schedule word w[count] from w[count-Nk] and w[count-1]
    always_comb begin
        prev_s    = words_r[count_r - 6'd1];
        back_s    = words_r[count_r - {2'b00, nk_r}];
        sub_src_s = (kmod_r == 4'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
        sub_s     = sub_word(sub_src_s);
        if (kmod_r == 4'd0) begin
            new_word_s = back_s ^ sub_s ^ {rcon_r, 24'h000000};
        end else if ((nk_r == 4'd8) && (kmod_r == 4'd4)) begin
            new_word_s = back_s ^ sub_s;
        end else begin
            new_word_s = back_s ^ prev_s;
        end
    end

    // Control FSM: load, expand one word per cycle, abort on re-init, flag rejected inits
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r    <= IDLE;
            count_r    <= 6'd0;
            total_r    <= 6'd0;
            nk_r       <= 4'd0;
            nr_r       <= 4'd0;
            kmod_r     <= 4'd0;
            rcon_r     <= 8'h00;
            busy_r     <= 1'b0;
            expanded_r <= 1'b0;
            err_r      <= 1'b0;
        end else if (start_s) begin
            state_r    <= EXPAND;
            count_r    <= {2'b00, nk_s};
            total_r    <= {nr_s + 4'd1, 2'b00};
            nk_r       <= nk_s;
            nr_r       <= nr_s;
            kmod_r     <= 4'd0;
            rcon_r     <= 8'h01;
            busy_r     <= 1'b1;
            expanded_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (ks.init_in) begin
                err_r <= 1'b1;
            end
            case (state_r)
                EXPAND: begin
                    count_r <= count_r + 6'd1;
                    kmod_r  <= (kmod_r == (nk_r - 4'd1)) ? 4'd0 : (kmod_r + 4'd1);
                    if (kmod_r == 4'd0) begin
                        rcon_r <= xtime(rcon_r);
                    end
                    if (last_s) begin
                        state_r    <= DONE;
                        busy_r     <= 1'b0;
                        expanded_r <= 1'b1;
                    end
                end
                default: state_r <= state_r;
            endcase
        end
    end

    // Word file is deliberately not reset; the count alone decides what is valid
    always_ff @(posedge clk_in) begin
        if (start_s) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < nk_s) begin
                    words_r[k] <= ks.key_in[255 - 32*k -: 32];
                end
            end
        end else if (wr_en_s) begin
            words_r[count_r] <= new_word_s;
        end
    end

    // Round-key read with write-first bypass of the word being generated this cycle
    always_comb begin
        rd_key_s   = 128'h0;
        rd_valid_s = ({ks.round_rd_in, 2'b11} < count_r) && (ks.round_rd_in <= nr_r);
        for (int k = 0; k < 4; k++) begin
            if (wr_en_s && (count_r == {ks.round_rd_in, 2'(k)})) begin
                rd_key_s[127 - 32*k -: 32] = new_word_s;
            end else begin
                rd_key_s[127 - 32*k -: 32] = words_r[{ks.round_rd_in, 2'(k)}];
            end
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_rd_comb
            assign ks.key_out      = rd_key_s;
            assign ks.rd_valid_out = rd_valid_s;
        end else begin : g_rd_reg
            logic [127:0] key_out_r;
            logic         rd_valid_r;

            // Registered read port
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    key_out_r  <= 128'h0;
                    rd_valid_r <= 1'b0;
                end else begin
                    key_out_r  <= rd_key_s;
                    rd_valid_r <= rd_valid_s;
                end
            end

            assign ks.key_out      = key_out_r;
            assign ks.rd_valid_out = rd_valid_r;
        end
    endgenerate

    assign ks.busy_out         = busy_r;
    assign ks.key_expanded_out = expanded_r;
    assign ks.nr_out           = nr_r;
    assign ks.err_out          = err_r;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: per-cycle transaction model pushes expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_aes_key_schedule;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_schedule_if ks();
    aes_key_schedule #(.MAX_KEY_BITS(256), .RD_LATENCY(1)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .ks(ks)
    );

    typedef struct {
        int           due;
        int           kind;   // 0 = read port, 1 = status flags
        int           round;
        logic         vld;
        logic [127:0] key;
        logic [6:0]   status; // {busy, expanded, err, nr}
    } exp_t;

    exp_t        sb_q[$];
    int          cycle = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  sbox_t [256];
    logic [7:0]  rcon_t [11];
    logic [31:0] m_w [64];
    int          m_cnt, m_nr, m_nk;
    logic        m_busy, m_exp, m_err;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p = 0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            a = a << 1;
            if ((a & 32'h100) != 0) a = a ^ 32'h11b;
        end
        return p;
    endfunction

    task automatic build_tables();
        int inv;
        logic [7:0] b;
        for (int a = 0; a < 256; a++) begin
            inv = 0;
            for (int c = 1; c < 256; c++) if (gmul(a, c) == 1) inv = c;
            b = 8'(inv);
            for (int i = 0; i < 8; i++)
                sbox_t[a][i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
        end
        rcon_t = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Textbook key expansion into m_w
    task automatic model_expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        int nr = nk + 6;
        for (int i = 0; i < 64; i++) m_w[i] = 32'h0;
        for (int i = 0; i < nk; i++) m_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = m_w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk], 24'h0};
            else if (nk > 6 && i % nk == 4) t = subw(t);
            m_w[i] = m_w[i-nk] ^ t;
        end
    endtask

    // One clock of stimulus: read expectation from pre-edge state, status from post-edge state
    task automatic step(input logic init, input logic [1:0] klen, input logic [255:0] key,
                        input int r, input bit kat_en = 1'b0, input logic [127:0] kat = 128'h0);
        exp_t e;
        ks.init_in     = init;
        ks.key_len_in  = klen;
        ks.key_in      = key;
        ks.round_rd_in = 4'(r);
        e.due    = cycle + 1;
        e.kind   = 0;
        e.round  = r;
        e.vld    = kat_en ? 1'b1 : ((4*r + 3 < m_cnt) && (r <= m_nr));
        e.key    = kat_en ? kat : {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
        e.status = 7'h0;
        sb_q.push_back(e);
        if (init && klen != 2'd3) begin
            m_nk = 4 + 2 * int'(klen);
            m_nr = m_nk + 6;
            model_expand(key, m_nk);
            m_cnt = m_nk;
            m_busy = 1'b1; m_exp = 1'b0; m_err = 1'b0;
        end else begin
            if (init) m_err = 1'b1;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 4*(m_nr+1)) begin m_busy = 1'b0; m_exp = 1'b1; end
            end
        end
        e.kind   = 1;
        e.status = {m_busy, m_exp, m_err, 4'(m_nr)};
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    function automatic int pick(input int hold);
        return (hold < 0) ? int'($urandom_range(0, 15)) : hold;
    endfunction

    task automatic run(input logic [1:0] klen, input logic [255:0] key, input int n, input int hold);
        step(1'b1, klen, key, pick(hold));
        for (int j = 0; j < n; j++) step(1'b0, klen, key, pick(hold));
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drain();
        @(negedge clk); #2;
        chk("scoreboard drained", 128'(sb_q.size()), 128'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " flags"}, {120'h0, ks.busy_out, ks.key_expanded_out, ks.err_out, ks.nr_out, ks.rd_valid_out}, 128'h0);
        chk({tag, " key_out"}, ks.key_out, 128'h0);
    endtask

    // Monitor: compares every expectation whose cycle has come
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cycle) begin
                e = sb_q.pop_front();
                if (e.kind == 0) begin
                    chk($sformatf("rd_valid round %0d", e.round), 128'(ks.rd_valid_out), 128'(e.vld));
                    if (e.vld) chk($sformatf("key_out round %0d", e.round), ks.key_out, e.key);
                end else begin
                    chk("status {busy,expanded,err,nr}",
                        128'({ks.busy_out, ks.key_expanded_out, ks.err_out, ks.nr_out}), 128'(e.status));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rk;
        logic [1:0]   kl;
        ks.init_in = 1'b0; ks.key_len_in = 2'd0; ks.key_in = 256'h0; ks.round_rd_in = 4'd0;
        m_cnt = 0; m_nr = 0; m_nk = 0; m_busy = 1'b0; m_exp = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 64; i++) m_w[i] = 32'h0;
        build_tables();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // AES-128 with round 2 held: also checks the early-read rise
        run(2'd0, K128, 42, 2);
        step(1'b0, 2'd0, K128, 10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        step(1'b0, 2'd0, K128, 0, 1'b1, K128[255:128]);
        run(2'd1, K192, 48, -1);
        step(1'b0, 2'd1, K192, 12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
        run(2'd2, K256, 54, -1);
        step(1'b0, 2'd2, K256, 14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);

        for (int n = 0; n < 3; n++) begin
            kl = 2'($urandom_range(0, 2));
            run(kl, rand_key(), 42 + 6 * int'(kl), -1);
        end

        // Abort a 256-bit expansion with a 128-bit init, then an illegal init
        run(2'd2, rand_key(), 19, -1);
        run(2'd0, K128, 42, -1);
        step(1'b0, 2'd0, K128, 10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        step(1'b1, 2'd3, rand_key(), 10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int r = 0; r < 16; r++) step(1'b0, 2'd3, 256'h0, r);
        step(1'b0, 2'd0, K128, 10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Asynchronous reset in the middle of an expansion
        run(2'd2, rand_key(), 15, -1);
        drain();
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        m_cnt = 0; m_nr = 0; m_busy = 1'b0; m_exp = 1'b0; m_err = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < 16; r++) step(1'b0, 2'd0, 256'h0, r);
        rk = rand_key();
        run(2'd1, rk, 48, -1);
        for (int r = 0; r < 16; r++) step(1'b0, 2'd1, rk, r);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
